// File: rtl/umi_pkg.sv
// rtl/umi_pkg.sv - UMI opcodes, packet field layout and endpoint FSM encoding
package umi_pkg;

    localparam logic [7:0] CMD_READ      = 8'h01;
    localparam logic [7:0] CMD_WRITE     = 8'h02;
    localparam logic [7:0] CMD_READ_RESP = 8'h81;
    localparam logic [7:0] CMD_ERR_RESP  = 8'h8F;

    localparam int CMD_LSB  = 0;
    localparam int SIZE_LSB = 8;
    localparam int DST_LSB  = 32;
    localparam int SRC_LSB  = 96;
    localparam int DATA_LSB = 160;
    localparam int CMD_W    = 8;
    localparam int SIZE_W   = 8;
    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 64;

    // log2 of the local data width in bytes
    localparam logic [7:0] MAX_SIZE = 8'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } umi_state_e;

    function automatic logic [255:0] umi_pack(
        input logic [7:0]  cmd,
        input logic [7:0]  size,
        input logic [63:0] dstaddr,
        input logic [63:0] srcaddr,
        input logic [63:0] data
    );
        logic [255:0] p;
        p = '0;
        p[CMD_LSB  +: CMD_W]  = cmd;
        p[SIZE_LSB +: SIZE_W] = size;
        p[DST_LSB  +: ADDR_W] = dstaddr;
        p[SRC_LSB  +: ADDR_W] = srcaddr;
        p[DATA_LSB +: DATA_W] = data;
        return p;
    endfunction

    function automatic logic [7:0] clamp_size(input logic [7:0] size);
        return (size > MAX_SIZE) ? MAX_SIZE : size;
    endfunction

    // Keeps only the low 2^size bytes of a data word
    function automatic logic [63:0] size_mask(input logic [7:0] size);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i*8 +: 8] = (size >= MAX_SIZE || i < (1 << size[1:0])) ? 8'hFF : 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/umi_unpack.sv
// rtl/umi_unpack.sv - combinational field extraction from a UMI packet
module umi_unpack
    import umi_pkg::*;
#(
    parameter int UW = 256,
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic [UW-1:0] packet,
    output logic [7:0]    cmd,
    output logic [7:0]    size,
    output logic [AW-1:0] dstaddr,
    output logic [AW-1:0] srcaddr,
    output logic [DW-1:0] data
);

    assign cmd     = packet[CMD_LSB  +: CMD_W];
    assign size    = packet[SIZE_LSB +: SIZE_W];
    assign dstaddr = packet[DST_LSB  +: AW];
    assign srcaddr = packet[SRC_LSB  +: AW];
    assign data    = packet[DATA_LSB +: DW];

    // Reserved bits are ignored on receive
    logic unused_reserved;
    assign unused_reserved = ^{packet[DST_LSB-1:SIZE_LSB+SIZE_W], packet[UW-1:DATA_LSB+DW]};

endmodule

// File: rtl/umi_endpoint.sv
// rtl/umi_endpoint.sv - UMI request responder driving a local register port
// UMI_ENDPOINT_ERR_EN: unknown commands answer with ERR_RESP instead of being dropped
module umi_endpoint
    import umi_pkg::*;
#(
    parameter int UW = 256,
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          udev_req_valid,
    input  logic [UW-1:0] udev_req_packet,
    output logic          udev_req_ready,
    output logic          udev_resp_valid,
    output logic [UW-1:0] udev_resp_packet,
    input  logic          udev_resp_ready,
    output logic [AW-1:0] loc_addr,
    output logic          loc_write,
    output logic          loc_read,
    output logic [DW-1:0] loc_wrdata,
    output logic [7:0]    loc_size,
    input  logic [DW-1:0] loc_rddata,
    input  logic          loc_ready
);

    logic [7:0]    req_cmd;
    logic [7:0]    req_size;
    logic [AW-1:0] req_dst;
    logic [AW-1:0] req_src;
    logic [DW-1:0] req_data;

    umi_unpack #(.UW(UW), .AW(AW), .DW(DW)) u_unpack (
        .packet  (udev_req_packet),
        .cmd     (req_cmd),
        .size    (req_size),
        .dstaddr (req_dst),
        .srcaddr (req_src),
        .data    (req_data)
    );

    umi_state_e    state_q, state_d;
    logic          is_read_q, is_read_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] src_q, src_d;
    logic [DW-1:0] wrdata_q, wrdata_d;
    logic [7:0]    size_q, size_d;
    logic [7:0]    loc_size_q, loc_size_d;
    logic [UW-1:0] resp_q, resp_d;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            is_read_q  <= 1'b0;
            addr_q     <= '0;
            src_q      <= '0;
            wrdata_q   <= '0;
            size_q     <= '0;
            loc_size_q <= '0;
            resp_q     <= '0;
        end else begin
            state_q    <= state_d;
            is_read_q  <= is_read_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
            wrdata_q   <= wrdata_d;
            size_q     <= size_d;
            loc_size_q <= loc_size_d;
            resp_q     <= resp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_read_d  = is_read_q;
        addr_d     = addr_q;
        src_d      = src_q;
        wrdata_d   = wrdata_q;
        size_d     = size_q;
        loc_size_d = loc_size_q;
        resp_d     = resp_q;
        case (state_q)
            ST_IDLE: begin
                if (udev_req_valid) begin
                    case (req_cmd)
                        CMD_READ, CMD_WRITE: begin
                            state_d    = ST_ACCESS;
                            is_read_d  = (req_cmd == CMD_READ);
                            addr_d     = req_dst;
                            src_d      = req_src;
                            wrdata_d   = req_data;
                            size_d     = req_size;
                            loc_size_d = clamp_size(req_size);
                        end
                        default: begin
`ifdef UMI_ENDPOINT_ERR_EN
                            state_d = ST_RESP;
                            resp_d  = umi_pack(CMD_ERR_RESP, req_size, req_src, req_dst, '0);
`endif
                        end
                    endcase
                end
            end
            ST_ACCESS: begin
                if (loc_ready) begin
                    if (is_read_q) begin
                        state_d = ST_RESP;
                        resp_d  = umi_pack(CMD_READ_RESP, size_q, src_q, addr_q,
                                           loc_rddata & size_mask(size_q));
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RESP: begin
                if (udev_resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign udev_req_ready   = (state_q == ST_IDLE);
    assign udev_resp_valid  = (state_q == ST_RESP);
    assign udev_resp_packet = resp_q;
    assign loc_read         = (state_q == ST_ACCESS) && is_read_q;
    assign loc_write        = (state_q == ST_ACCESS) && !is_read_q;
    assign loc_addr         = addr_q;
    assign loc_wrdata       = wrdata_q;
    assign loc_size         = loc_size_q;

endmodule

// File: tb/tb_umi_endpoint.sv
// tb/tb_umi_endpoint.sv - self-checking bench for umi_endpoint
module tb_umi_endpoint;

    logic         clk = 1'b0;
    logic         nreset;
    logic         udev_req_valid;
    logic [255:0] udev_req_packet;
    logic         udev_req_ready;
    logic         udev_resp_valid;
    logic [255:0] udev_resp_packet;
    logic         udev_resp_ready;
    logic [63:0]  loc_addr;
    logic         loc_write;
    logic         loc_read;
    logic [63:0]  loc_wrdata;
    logic [7:0]   loc_size;
    logic [63:0]  loc_rddata;
    logic         loc_ready;

    int n_cmp = 0;
    int n_err = 0;

    umi_endpoint dut (
        .clk              (clk),
        .nreset           (nreset),
        .udev_req_valid   (udev_req_valid),
        .udev_req_packet  (udev_req_packet),
        .udev_req_ready   (udev_req_ready),
        .udev_resp_valid  (udev_resp_valid),
        .udev_resp_packet (udev_resp_packet),
        .udev_resp_ready  (udev_resp_ready),
        .loc_addr         (loc_addr),
        .loc_write        (loc_write),
        .loc_read         (loc_read),
        .loc_wrdata       (loc_wrdata),
        .loc_size         (loc_size),
        .loc_rddata       (loc_rddata),
        .loc_ready        (loc_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pkt(input logic [7:0] cmd, input logic [7:0] size,
                                         input logic [63:0] dst, input logic [63:0] src,
                                         input logic [63:0] data);
        logic [255:0] p;
        p = '0;
        p[7:0]     = cmd;
        p[15:8]    = size;
        p[95:32]   = dst;
        p[159:96]  = src;
        p[223:160] = data;
        return p;
    endfunction

    // Read response: addresses swapped, data truncated to 2^size bytes
    function automatic logic [255:0] model_read_resp(input logic [7:0] size, input logic [63:0] dst,
                                                     input logic [63:0] src, input logic [63:0] rdd);
        logic [63:0] d;
        if (size >= 8'd3) d = rdd;
        else d = rdd % (64'd1 << (8 * (1 << size)));
        return pkt(8'h81, size, src, dst, d);
    endfunction

    task automatic idle_checks(input string tag);
        check({tag, "_req_ready"}, udev_req_ready, 1);
        check({tag, "_resp_valid"}, udev_resp_valid, 0);
        check({tag, "_loc_read"}, loc_read, 0);
        check({tag, "_loc_write"}, loc_write, 0);
    endtask

    task automatic do_txn(input logic [7:0] cmd, input logic [7:0] size, input logic [63:0] dst,
                          input logic [63:0] src, input logic [63:0] data, input logic [63:0] rdd,
                          input int lat, input int bp);
        logic is_rd;
        logic [255:0] exp_pkt;
        is_rd = (cmd == 8'h01);
        check("accept_ready", udev_req_ready, 1);
        udev_req_valid  = 1'b1;
        udev_req_packet = pkt(cmd, size, dst, src, data);
        @(negedge clk);
        udev_req_valid  = 1'b0;
        udev_req_packet = '0;
        for (int k = 0; k <= lat; k++) begin
            check("strobe_read", loc_read, is_rd);
            check("strobe_write", loc_write, !is_rd);
            check("loc_addr", loc_addr, dst);
            if (!is_rd) check("loc_wrdata", loc_wrdata, data);
            check("loc_size", loc_size, (size > 8'd3) ? 8'd3 : size);
            check("busy_req_ready", udev_req_ready, 0);
            check("busy_resp_valid", udev_resp_valid, 0);
            loc_ready  = (k == lat);
            loc_rddata = (k == lat) ? rdd : {$urandom, $urandom};
            @(negedge clk);
        end
        loc_ready = 1'b0;
        if (is_rd) begin
            exp_pkt = model_read_resp(size, dst, src, rdd);
            for (int k = 0; k < bp; k++) begin
                check("resp_hold_valid", udev_resp_valid, 1);
                check("resp_hold_packet", udev_resp_packet, exp_pkt);
                check("resp_hold_req_ready", udev_req_ready, 0);
                check("resp_hold_strobe", {loc_read, loc_write}, 0);
                @(negedge clk);
            end
            check("resp_valid", udev_resp_valid, 1);
            check("resp_packet", udev_resp_packet, exp_pkt);
            udev_resp_ready = 1'b1;
            @(negedge clk);
            udev_resp_ready = 1'b0;
        end
        idle_checks("after_txn");
    endtask

    task automatic unknown_cmd(input logic [7:0] size, input logic [63:0] dst, input logic [63:0] src);
        udev_req_valid  = 1'b1;
        udev_req_packet = pkt(8'h33, size, dst, src, 64'hFFFF_0000_FFFF_0000);
        @(negedge clk);
        udev_req_valid  = 1'b0;
        udev_req_packet = '0;
        check("unk_strobe", {loc_read, loc_write}, 0);
`ifdef UMI_ENDPOINT_ERR_EN
        check("unk_err_valid", udev_resp_valid, 1);
        check("unk_err_packet", udev_resp_packet, pkt(8'h8F, size, src, dst, 64'h0));
        check("unk_req_ready", udev_req_ready, 0);
        udev_resp_ready = 1'b1;
        @(negedge clk);
        udev_resp_ready = 1'b0;
`else
        check("unk_no_resp", udev_resp_valid, 0);
        check("unk_req_ready", udev_req_ready, 1);
        @(negedge clk);
`endif
        idle_checks("after_unk");
    endtask

    initial begin
        logic [7:0] r_cmd;
        logic [7:0] r_size;

        nreset          = 1'b0;
        udev_req_valid  = 1'b0;
        udev_req_packet = '0;
        udev_resp_ready = 1'b0;
        loc_rddata      = '0;
        loc_ready       = 1'b0;
        #1;
        check("rst_req_ready", udev_req_ready, 1);
        check("rst_resp_valid", udev_resp_valid, 0);
        check("rst_resp_packet", udev_resp_packet, 0);
        check("rst_loc_read", loc_read, 0);
        check("rst_loc_write", loc_write, 0);
        check("rst_loc_addr", loc_addr, 0);
        check("rst_loc_wrdata", loc_wrdata, 0);
        check("rst_loc_size", loc_size, 0);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);

        do_txn(8'h02, 8'd3, 64'h1000, 64'h0, 64'hDEADBEEF_CAFEF00D, 64'h0, 0, 0);
        do_txn(8'h01, 8'd2, 64'h2000, 64'h9000, 64'h0, 64'h11223344_55667788, 0, 0);
        do_txn(8'h01, 8'd3, 64'h3000, 64'hA000, 64'h0, 64'h0102030405060708, 5, 4);
        unknown_cmd(8'd1, 64'h4000, 64'hB000);

        for (int i = 0; i < 24; i++) begin
            r_cmd  = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
            r_size = 8'($urandom_range(0, 5));
            do_txn(r_cmd, r_size, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Reset while a read response is pending
        udev_req_valid  = 1'b1;
        udev_req_packet = pkt(8'h01, 8'd3, 64'h5000, 64'hC000, 64'h0);
        @(negedge clk);
        udev_req_valid  = 1'b0;
        loc_ready       = 1'b1;
        loc_rddata      = 64'hAAAA_BBBB_CCCC_DDDD;
        @(negedge clk);
        loc_ready = 1'b0;
        check("pre_rst_resp_valid", udev_resp_valid, 1);
        #2;
        nreset = 1'b0;
        #1;
        check("mid_rst_resp_valid", udev_resp_valid, 0);
        check("mid_rst_req_ready", udev_req_ready, 1);
        check("mid_rst_strobe", {loc_read, loc_write}, 0);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        do_txn(8'h02, 8'd0, 64'h6000, 64'h0, 64'h0000_0000_0000_00A5, 64'h0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
